// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported 8-word data memory: pipeline port A
// has default priority, debug/DMA port B gets starvation promotion and locked bursts.
module data_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [2:0]  a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_lock,
  input  logic [2:0]  b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic [2:0]  mem_read_addr,
  output logic [2:0]  mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  fsm_state
);

  // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt in the
  // same cycle; the access happens in that cycle and a read returns rvalid/rdata
  // exactly one cycle later. Ungranted requests are never latched.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          b_resume;
  logic          pick_a;
  logic          pick_b;

  // b_resume gives B the cycle right after the A grant that ended its burst.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (a_req && burst_cnt == BURST_TOP)
      pick_a = 1'b1;
    else if (state == OWN_B && b_lock && b_req && burst_cnt < BURST_TOP)
      pick_b = 1'b1;
    else if (b_req && (b_resume || starve_cnt == STARVE_TOP))
      pick_b = 1'b1;
    else if (a_req)
      pick_a = 1'b1;
    else if (b_req)
      pick_b = 1'b1;
  end

  // Gating with rst_n drops grants and enables the moment reset asserts.
  assign a_gnt = rst_n & pick_a;
  assign b_gnt = rst_n & pick_b;

  always_comb begin
    mem_read_addr    = 3'd0;
    mem_write_addr   = 3'd0;
    mem_write_data   = 32'd0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    if (a_gnt) begin
      mem_read_addr    = a_addr;
      mem_write_addr   = a_addr;
      mem_write_data   = a_wdata;
      mem_read_enable  = ~a_we;
      mem_write_enable = a_we;
    end else if (b_gnt) begin
      mem_read_addr    = b_addr;
      mem_write_addr   = b_addr;
      mem_write_data   = b_wdata;
      mem_read_enable  = ~b_we;
      mem_write_enable = b_we;
    end
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      b_resume   <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= 32'd0;
      b_rdata    <= 32'd0;
    end else begin
      if (a_gnt)      state <= OWN_A;
      else if (b_gnt) state <= OWN_B;
      else            state <= IDLE;

      if (b_gnt || !b_req)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_TOP)
        starve_cnt <= starve_cnt + 1'b1;

      if (!b_gnt)
        burst_cnt <= '0;
      else if (burst_cnt != BURST_TOP)
        burst_cnt <= burst_cnt + 1'b1;

      b_resume <= a_gnt && (burst_cnt == BURST_TOP);

      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) a_rdata <= mem_read_data;
      if (b_gnt && !b_we) b_rdata <= mem_read_data;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_LIMIT, default 4: consecutive denied cycles of port B before B is promoted.
REQ-002 SHALL provide parameter BURST_MAX, default 8: maximum consecutive locked grants to port B.
REQ-003 SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL provide ports a_req / a_we, input, 1 each: port A (pipeline MEM stage) access request and write flag.
REQ-006 SHALL provide ports a_addr, input, 3 and a_wdata, input, 32: port A word address and write data.
REQ-007 SHALL provide ports a_gnt, output, 1; a_rvalid, output, 1; a_rdata, output, 32: port A grant, read-valid and read data.
REQ-008 SHALL provide ports b_req, b_we, b_lock (input, 1 each), b_addr (input, 3), b_wdata (input, 32): port B (debug/DMA) request, write flag, burst lock, address and write data.
REQ-009 SHALL provide ports b_gnt, output, 1; b_rvalid, output, 1; b_rdata, output, 32: port B grant, read-valid and read data.
REQ-010 SHALL provide memory-side outputs mem_read_addr (3), mem_write_addr (3), mem_write_data (32), mem_read_enable (1), mem_write_enable (1).
REQ-011 SHALL provide mem_read_data, input, 32: combinational read result from the memory.

Function
REQ-012 SHALL grant at most one port per cycle; a_gnt and b_gnt are combinational from requests and registered state, and are never both 1.
REQ-013 SHALL route the granted port's addr/wdata to both mem address buses in the grant cycle; mem_write_enable = gnt & we; mem_read_enable = gnt & ~we.
REQ-014 With no grant, mem enables SHALL be 0 and mem address/data outputs SHALL be 0.
REQ-015 SHALL register mem_read_data into the granted port's rdata at the end of a read grant cycle; that port's rvalid is 1 for exactly the following cycle.
REQ-016 On writes, rvalid SHALL stay 0; the rdata of each port SHALL hold its last value until its next read completes.
REQ-017 Requesters SHALL hold req, we, addr and wdata stable until gnt is seen; an ungranted request is not latched.
REQ-018 The FSM SHALL have three states: IDLE (no grant last cycle), OWN_A (A granted last cycle), OWN_B (B granted last cycle); the next state follows the grant issued this cycle.
REQ-019 Default priority SHALL be A over B.
REQ-020 SHALL keep starve_cnt, saturating at STARVE_LIMIT: +1 when b_req=1 and b_gnt=0; cleared when b_gnt=1 or b_req=0.
REQ-021 When starve_cnt == STARVE_LIMIT and b_req=1, SHALL grant B even if a_req=1.
REQ-022 In OWN_B with b_lock=1 and b_req=1, SHALL grant B again regardless of a_req while burst_cnt < BURST_MAX.
REQ-023 SHALL keep burst_cnt: +1 on each consecutive B grant, cleared on any cycle without a B grant.
REQ-024 When burst_cnt reaches BURST_MAX with a_req=1, SHALL grant A for one cycle before B can be granted again.
REQ-025 With a_req=0, B SHALL be granted whenever it requests, with no burst limit enforced.
REQ-026 Lock SHALL take effect only in OWN_B; b_lock asserted from IDLE or OWN_A SHALL be ignored until B is next granted.

Reset
REQ-027 While rst_n=0, SHALL force state IDLE, starve_cnt=0, burst_cnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, with gnt and mem enables 0.
REQ-028 Reset asserted mid-access SHALL abort it immediately, with no rvalid issued afterward.
REQ-029 The first grant SHALL be possible in the first clock cycle after rst_n rises.

Verification
REQ-030 Reset check: after reset, A reads addr 3 while the memory returns 0x00000004 -> a_gnt=1 in the same cycle, then a_rvalid=1 with a_rdata=0x00000004 in the next cycle.
REQ-031 Collision: a_req and b_req held continuously, STARVE_LIMIT=4 -> A granted 4 cycles, B granted on the 5th, then A resumes.
REQ-032 Burst: b_lock=1, b_req held, a_req held from the burst's 2nd cycle, BURST_MAX=8 -> 8 consecutive B grants, 1 A grant, then B resumes.
REQ-033 Write-then-read: B writes 0xDEADBEEF to addr 5, then A reads addr 5 -> mem_write_enable=1 for one cycle with b_rvalid=0; a_rdata=0xDEADBEEF.
REQ-034 Async reset: rst_n driven low between clock edges during a B read -> b_gnt, mem enables and rvalid drop to 0 without waiting for a clock edge.
